// File: rtl/hwpe_color_converter_pipe_if.sv
// Valid/ready stream bundle carrying packed pixel beats plus byte strobes.
// source/sink are the producer/consumer views; master/slave are aliases of the same.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 96
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input  ready);
    modport sink   (input  valid, data, strb, output ready);
    modport master (output valid, data, strb, input  ready);
    modport slave  (input  valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_color_converter_pipe.sv
// Per-beat RGB<->YCbCr (BT.601 full range, Q8) stream converter with an
// N-deep elastic register chain between the input and output streams.

module hwpe_color_converter_pixel #(
    parameter int unsigned CW = 8
) (
    input  logic            to_ycc,
    input  logic [3*CW-1:0] pix,
    output logic [3*CW-1:0] res
);
    localparam int OFF  = 1 << (CW - 1);
    localparam int MAXV = (1 << CW) - 1;

    function automatic logic [CW-1:0] sat(input int x);
        if (x < 0)    return '0;
        if (x > MAXV) return '1;
        return x[CW-1:0];
    endfunction

    int a, b, c, u, v;

    // Signed 32-bit intermediates cannot overflow for CW <= 12; >>> floors.
    always_comb begin
        a = int'(pix[CW-1:0]);
        b = int'(pix[2*CW-1:CW]);
        c = int'(pix[3*CW-1:2*CW]);
        u = b - OFF;
        v = c - OFF;
        if (to_ycc)
            res = {sat(((128*a - 107*b - 21*c + 128) >>> 8) + OFF),
                   sat(((-43*a - 85*b + 128*c + 128) >>> 8) + OFF),
                   sat((77*a + 150*b + 29*c + 128) >>> 8)};
        else
            res = {sat(a + ((454*u + 128) >>> 8)),
                   sat(a - ((88*u + 183*v + 128) >>> 8)),
                   sat(a + ((359*v + 128) >>> 8))};
    end
endmodule

module hwpe_color_converter_stage #(
    parameter int unsigned DW = 96,
    parameter int unsigned SW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    input  logic [SW-1:0] up_strb,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data,
    output logic [SW-1:0] dn_strb
);
    assign up_ready = !dn_valid || dn_ready;

    // Payload only loads with a valid beat so it stays frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_strb  <= '0;
        end else if (clear) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
                dn_strb <= up_strb;
            end
        end
    end
endmodule

module hwpe_color_converter_pipe #(
    parameter int unsigned STREAM_WIDTH  = 96,
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned PIPE_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [1:0]                    mode,
    hwpe_stream_intf_stream.sink          in,
    hwpe_stream_intf_stream.source        out,
    output logic                          busy,
    output logic [31:0]                   beat_cnt
);
    localparam int unsigned CW     = CHANNEL_WIDTH;
    localparam int unsigned PW     = 3 * CW;
    localparam int unsigned NB_PIX = STREAM_WIDTH / PW;
    localparam int unsigned USED   = NB_PIX * PW;
    localparam int unsigned SW     = STREAM_WIDTH / 8;

    logic [NB_PIX-1:0][PW-1:0] pix_res;
    logic [STREAM_WIDTH-1:0]   cvt;
    logic                      do_cvt;

    assign do_cvt = (mode == 2'd1) || (mode == 2'd2);

    for (genvar i = 0; i < NB_PIX; i++) begin : g_pix
        hwpe_color_converter_pixel #(.CW(CW)) u_pix (
            .to_ycc (mode == 2'd1),
            .pix    (in.data[i*PW +: PW]),
            .res    (pix_res[i])
        );
    end

    // Bypass keeps the whole beat, unused upper bits included.
    always_comb begin
        cvt = in.data;
        if (do_cvt) begin
            cvt           = '0;
            cvt[USED-1:0] = pix_res;
        end
    end

    if (PIPE_STAGES == 0) begin : g_comb
        assign out.valid = in.valid && !clear;
        assign in.ready  = out.ready && !clear;
        assign out.data  = cvt;
        assign out.strb  = in.strb;
        assign busy      = in.valid;
    end else begin : g_pipe
        logic [PIPE_STAGES:0]                   vld_pipe;
        logic [PIPE_STAGES:0]                   rdy_pipe;
        logic [PIPE_STAGES:0][STREAM_WIDTH-1:0] dat_pipe;
        logic [PIPE_STAGES:0][SW-1:0]           stb_pipe;

        assign vld_pipe[0]           = in.valid;
        assign dat_pipe[0]           = cvt;
        assign stb_pipe[0]           = in.strb;
        assign rdy_pipe[PIPE_STAGES] = out.ready;

        for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stg
            hwpe_color_converter_stage #(.DW(STREAM_WIDTH), .SW(SW)) u_stg (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .up_valid (vld_pipe[k-1]),
                .up_ready (rdy_pipe[k-1]),
                .up_data  (dat_pipe[k-1]),
                .up_strb  (stb_pipe[k-1]),
                .dn_valid (vld_pipe[k]),
                .dn_ready (rdy_pipe[k]),
                .dn_data  (dat_pipe[k]),
                .dn_strb  (stb_pipe[k])
            );
        end

        assign in.ready  = rdy_pipe[0] && !clear;
        assign out.valid = vld_pipe[PIPE_STAGES];
        assign out.data  = dat_pipe[PIPE_STAGES];
        assign out.strb  = stb_pipe[PIPE_STAGES];
        assign busy      = |vld_pipe[PIPE_STAGES:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      beat_cnt <= '0;
        else if (clear)                  beat_cnt <= '0;
        else if (out.valid && out.ready) beat_cnt <= beat_cnt + 32'd1;
    end
endmodule
